// File: rtl/instruction_sequencer_if.sv
// Bus bundle between the instruction sequencer, its instruction memory and
// the I2C request/response engine.
interface instruction_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       read_data;
    logic [3:0]        mem_error;
    logic              i2c_req_valid;
    logic              i2c_req_ready;
    logic              i2c_rw;
    logic [7:0]        i2c_dev;
    logic [7:0]        i2c_reg;
    logic [7:0]        i2c_wdata;
    logic              i2c_rsp_valid;
    logic              i2c_rsp_nack;
    logic [7:0]        i2c_rsp_data;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [3:0]        err_code;

    modport master (
        input  start, read_data, mem_error, i2c_req_ready,
               i2c_rsp_valid, i2c_rsp_nack, i2c_rsp_data,
        output reg_addr, i2c_req_valid, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
               rd_data, rd_valid, busy, done, err_code
    );

    modport slave (
        output start, read_data, mem_error, i2c_req_ready,
               i2c_rsp_valid, i2c_rsp_nack, i2c_rsp_data,
        input  reg_addr, i2c_req_valid, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
               rd_data, rd_valid, busy, done, err_code
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetches 32-bit instructions from a 1-cycle-latency memory and turns them
// into I2C read/write requests until an END opcode, the last address or an error.
module instruction_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int LAST_ADDR   = 255,
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    instruction_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_RD  = 8'h01;
    localparam logic [7:0] OP_WR  = 8'h02;
    localparam logic [7:0] OP_END = 8'hFF;

    localparam logic [3:0] ERR_NONE = 4'd0;
    localparam logic [3:0] ERR_MEM  = 4'd1;
    localparam logic [3:0] ERR_OP   = 4'd2;
    localparam logic [3:0] ERR_NACK = 4'd3;
    localparam logic [3:0] ERR_TMO  = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_ADVANCE = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic              req_valid_q, req_valid_d;
    logic              rw_q, rw_d;
    logic [7:0]        dev_q, dev_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        op_s;

    assign op_s = bus.read_data[31:24];

    // Next-state and registered-output computation for the sequencer FSM
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        reg_addr_d  = reg_addr_q;
        req_valid_d = req_valid_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (bus.start) begin
                    pc_d       = '0;
                    reg_addr_d = '0;
                    err_d      = ERR_NONE;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                // A bad address makes the fetched word meaningless, so it outranks the opcode
                if (bus.mem_error != 4'd0) begin
                    err_d   = ERR_MEM;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    case (op_s)
                        OP_NOP: state_d = S_ADVANCE;
                        OP_RD, OP_WR: begin
                            rw_d        = (op_s == OP_RD);
                            dev_d       = bus.read_data[23:16];
                            reg_d       = bus.read_data[15:8];
                            wdata_d     = bus.read_data[7:0];
                            req_valid_d = 1'b1;
                            state_d     = S_ISSUE;
                        end
                        OP_END: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                        default: begin
                            err_d   = ERR_OP;
                            busy_d  = 1'b0;
                            state_d = S_ERR;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (bus.i2c_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                // A response arriving in the final counted cycle still beats the timeout
                if (bus.i2c_rsp_valid) begin
                    if (bus.i2c_rsp_nack) begin
                        err_d   = ERR_NACK;
                        busy_d  = 1'b0;
                        state_d = S_ERR;
                    end else begin
                        if (rw_q) begin
                            rd_data_d  = bus.i2c_rsp_data;
                            rd_valid_d = 1'b1;
                        end else begin
                            rd_data_d  = rd_data_q;
                        end
                        state_d = S_ADVANCE;
                    end
                end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
                    err_d   = ERR_TMO;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADVANCE: begin
                if (pc_q == ADDR_W'(LAST_ADDR)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    pc_d       = pc_q + ADDR_W'(1);
                    reg_addr_d = pc_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
            end
            default: begin
                req_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            reg_addr_q  <= '0;
            req_valid_q <= 1'b0;
            rw_q        <= 1'b0;
            dev_q       <= 8'd0;
            reg_q       <= 8'd0;
            wdata_q     <= 8'd0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 4'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            reg_addr_q  <= reg_addr_d;
            req_valid_q <= req_valid_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.reg_addr      = reg_addr_q;
    assign bus.i2c_req_valid = req_valid_q;
    assign bus.i2c_rw        = rw_q;
    assign bus.i2c_dev       = dev_q;
    assign bus.i2c_reg       = reg_q;
    assign bus.i2c_wdata     = wdata_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err_code      = err_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed and random programs checked
// against a program-walking reference model of the instruction set.
module tb_instruction_sequencer;
    localparam int TMO  = 1024;
    localparam int LAST = 255;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instruction_sequencer_if #(.ADDR_W(8)) bus ();

    instruction_sequencer #(
        .ADDR_W(8), .LAST_ADDR(LAST), .RSP_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem  [256];
    logic [3:0]  merr [256];
    int          rdly [256];
    int          rspd [256];
    bit          nack [256];
    logic [7:0]  rdat [256];

    int n_asrt = 0;
    int n_fail = 0;

    logic [24:0] obs_req[$];
    logic [24:0] exp_req[$];
    logic [7:0]  obs_rd[$];
    logic [7:0]  exp_rd[$];
    int          obs_done, obs_busy, obs_max, obs_tw;
    bit          obs_a1;
    int          exp_done, exp_busy, exp_max;
    logic [3:0]  exp_err;
    bit          noise_en;

    // Synchronous memory: word for the address seen one cycle earlier
    initial begin : memory_model
        logic [7:0] a;
        a = 8'd0;
        bus.read_data = 32'd0;
        bus.mem_error = 4'd0;
        forever begin
            @(negedge clk);
            bus.read_data = mem[a];
            bus.mem_error = merr[a];
            a = bus.reg_addr;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog(input logic [31:0] fill);
        for (int i = 0; i < 256; i++) begin
            mem[i] = fill; merr[i] = 4'd0; rdly[i] = 0;
            rspd[i] = 0; nack[i] = 1'b0; rdat[i] = 8'd0;
        end
    endtask

    // Walk the program as the instruction set defines it
    task automatic model();
        int pc;
        bit fin;
        logic [7:0] op;
        exp_req.delete(); exp_rd.delete();
        exp_err = 4'd0; exp_done = 0; exp_busy = 0; exp_max = 0;
        pc = 0; fin = 1'b0;
        while (!fin) begin
            if (pc > exp_max) exp_max = pc;
            exp_busy += 2;
            op = mem[pc][31:24];
            if (merr[pc] != 4'd0) begin
                exp_err = 4'd1; fin = 1'b1;
            end else if (op == 8'h00 || op == 8'h01 || op == 8'h02) begin
                bit ok;
                ok = 1'b1;
                if (op != 8'h00) begin
                    exp_req.push_back({op == 8'h01, mem[pc][23:0]});
                    exp_busy += rdly[pc] + 1;
                    if (rspd[pc] >= TMO) begin
                        exp_busy += TMO; exp_err = 4'd4; fin = 1'b1; ok = 1'b0;
                    end else begin
                        exp_busy += rspd[pc] + 1;
                        if (nack[pc]) begin
                            exp_err = 4'd3; fin = 1'b1; ok = 1'b0;
                        end else if (op == 8'h01) begin
                            exp_rd.push_back(rdat[pc]);
                        end
                    end
                end
                if (ok) begin
                    exp_busy += 1;
                    if (pc == LAST) begin exp_done = 1; fin = 1'b1; end
                    else pc++;
                end
            end else if (op == 8'hFF) begin
                exp_done = 1; fin = 1'b1;
            end else begin
                exp_err = 4'd2; fin = 1'b1;
            end
        end
    endtask

    // Start the program and act as I2C engine until busy drops
    task automatic run_prog(input string tag, input int budget, input int glitch);
        int cyc, vcnt, w, d;
        bit pend, pend_start, prev_hold;
        logic [24:0] prev_f, cur_f;
        logic [7:0] pa;
        obs_req.delete(); obs_rd.delete();
        obs_done = 0; obs_busy = 0; obs_max = 0; obs_tw = -1; obs_a1 = 1'b0;
        vcnt = 0; w = 0; d = 0; pend = 1'b0; pend_start = 1'b0; prev_hold = 1'b0;
        prev_f = 25'd0; pa = 8'd0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        chk({tag, " start addr"}, bus.reg_addr, 64'd0);
        chk({tag, " err cleared"}, bus.err_code, 64'd0);
        cyc = 0;
        forever begin
            cur_f = {bus.i2c_rw, bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata};
            if (bus.done) obs_done++;
            if (bus.rd_valid) obs_rd.push_back(bus.rd_data);
            if (int'(bus.reg_addr) > obs_max) obs_max = int'(bus.reg_addr);
            if (bus.reg_addr == 8'd1) obs_a1 = 1'b1;
            if (bus.err_code == 4'd4 && obs_tw < 0) obs_tw = w;
            if (prev_hold) chk({tag, " request held"}, {bus.i2c_req_valid, cur_f}, {1'b1, prev_f});
            if (!bus.busy) break;
            obs_busy++;
            if (cyc >= budget) begin
                chk({tag, " finished in budget"}, bus.busy, 64'd0);
                break;
            end
            bus.start = (cyc == glitch);
            bus.i2c_rsp_valid = 1'b0;
            bus.i2c_rsp_nack = 1'b0;
            prev_hold = 1'b0;
            if (pend_start) begin pend = 1'b1; pend_start = 1'b0; w = 0; end
            if (pend) begin
                if (w == d) begin
                    bus.i2c_rsp_valid = 1'b1;
                    bus.i2c_rsp_nack = nack[pa];
                    bus.i2c_rsp_data = rdat[pa];
                    pend = 1'b0;
                end
                w++;
            end else if (noise_en && $urandom_range(0, 7) == 0) begin
                bus.i2c_rsp_valid = 1'b1;
                bus.i2c_rsp_nack = ($urandom_range(0, 1) != 0);
                bus.i2c_rsp_data = 8'($urandom);
            end
            if (bus.i2c_req_valid) begin
                if (vcnt >= rdly[bus.reg_addr]) begin
                    bus.i2c_req_ready = 1'b1;
                    obs_req.push_back(cur_f);
                    pend_start = 1'b1;
                    pa = bus.reg_addr;
                    d = rspd[pa];
                    vcnt = 0;
                end else begin
                    bus.i2c_req_ready = 1'b0;
                    vcnt++;
                    prev_hold = 1'b1;
                    prev_f = cur_f;
                end
            end else begin
                bus.i2c_req_ready = 1'b0;
                vcnt = 0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.i2c_req_ready = 1'b0; bus.i2c_rsp_valid = 1'b0;
    endtask

    task automatic check_run(input string tag);
        chk({tag, " done pulses"}, obs_done, exp_done);
        chk({tag, " busy cycles"}, obs_busy, exp_busy);
        chk({tag, " max reg_addr"}, obs_max, exp_max);
        chk({tag, " request count"}, obs_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < obs_req.size(); i++)
            chk({tag, " request"}, obs_req[i], exp_req[i]);
        chk({tag, " read count"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            chk({tag, " read byte"}, obs_rd[i], exp_rd[i]);
        @(negedge clk);
        chk({tag, " err_code"}, bus.err_code, exp_err);
        chk({tag, " quiet after end"}, {bus.done, bus.rd_valid, bus.i2c_req_valid, bus.busy}, 64'd0);
    endtask

    task automatic outputs_reset(input string tag);
        chk({tag, " outputs at reset"},
            {bus.reg_addr, bus.i2c_req_valid, bus.i2c_rw, bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata,
             bus.rd_data, bus.rd_valid, bus.busy, bus.done, bus.err_code}, 64'd0);
    endtask

    // Reset while a request is pending or a response is awaited
    task automatic rst_abort(input string tag, input bit at_issue);
        clear_prog(32'hFF000000);
        mem[0] = 32'h013A4B00; rspd[0] = 100;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, " valid in issue"}, bus.i2c_req_valid, 64'd1);
        if (!at_issue) begin
            bus.i2c_req_ready = 1'b1;
            @(negedge clk); bus.i2c_req_ready = 1'b0;
            chk({tag, " waiting"}, {bus.i2c_req_valid, bus.busy}, 64'd1);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        outputs_reset(tag);
        repeat (6) begin
            @(negedge clk);
            chk({tag, " no activity"}, {bus.i2c_req_valid, bus.done, bus.busy}, 64'd0);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.i2c_req_ready = 1'b0; bus.i2c_rsp_valid = 1'b0;
        bus.i2c_rsp_nack = 1'b0; bus.i2c_rsp_data = 8'd0; noise_en = 1'b0;
        clear_prog(32'hFF000000);
        repeat (3) @(negedge clk);
        outputs_reset("por");
        reset = 1'b0;

        clear_prog(32'hFF000000);
        mem[0] = 32'h0200F0A5;
        model(); run_prog("write", 200, -1); check_run("write");
        chk("write fields", obs_req.size() > 0 ? obs_req[0] : 25'h1FFFFFF, {1'b0, 24'h00F0A5});

        clear_prog(32'hFF000000);
        mem[0] = 32'h011D2B00; rdat[0] = 8'h5C; rspd[0] = 3;
        model(); run_prog("read", 200, -1); check_run("read");
        chk("read rd_data held", bus.rd_data, 64'h5C);

        clear_prog(32'hFF000000);
        mem[0] = 32'h02112233; rdly[0] = 5;
        model(); run_prog("ready stall", 200, -1); check_run("ready stall");

        clear_prog(32'hFF000000);
        mem[0] = 32'h02445566; mem[1] = 32'h02778899; nack[0] = 1'b1; rspd[0] = 2;
        model(); run_prog("nack", 200, -1); check_run("nack");
        chk("nack no fetch of 1", obs_a1, 64'd0);

        clear_prog(32'hFF000000);
        mem[0] = 32'h0200F0A5;
        model(); run_prog("restart", 200, 3); check_run("restart");

        clear_prog(32'hFF000000);
        mem[0] = 32'h01505100; rspd[0] = TMO;
        model(); run_prog("timeout", 3000, -1); check_run("timeout");
        chk("timeout latency", obs_tw, TMO);
        bus.i2c_rsp_valid = 1'b1; bus.i2c_rsp_data = 8'h77;
        @(negedge clk); bus.i2c_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late response ignored", {bus.rd_valid, bus.busy, bus.err_code}, 64'd4);

        clear_prog(32'hFF000000);
        mem[0] = 32'h01606100; rspd[0] = TMO - 1; rdat[0] = 8'h3C;
        model(); run_prog("response at limit", 3000, -1); check_run("response at limit");

        clear_prog(32'hFF000000);
        mem[0] = 32'h00000000; mem[1] = 32'h03010203;
        model(); run_prog("illegal op", 200, -1); check_run("illegal op");

        clear_prog(32'hFF000000);
        mem[0] = 32'h02010203; merr[0] = 4'd1;
        model(); run_prog("mem error", 200, -1); check_run("mem error");

        clear_prog(32'h00000000);
        model(); run_prog("all nops", 2000, 10); check_run("all nops");
        chk("all nops no wrap", bus.reg_addr, 64'd255);

        noise_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int n;
            clear_prog(32'hFF000000);
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r < 4) mem[i] = {8'h00, 24'($urandom)};
                else if (r < 9) mem[i] = {8'h02, 24'($urandom)};
                else if (r < 14) mem[i] = {8'h01, 24'($urandom)};
                else if (r == 14) mem[i] = {8'($urandom_range(3, 254)), 24'($urandom)};
                else begin mem[i] = {8'h02, 24'($urandom)}; merr[i] = 4'($urandom_range(1, 15)); end
                rdly[i] = $urandom_range(0, 4);
                rspd[i] = $urandom_range(0, 6);
                nack[i] = ($urandom_range(0, 9) == 0);
                rdat[i] = 8'($urandom);
            end
            model(); run_prog("random", 5000, $urandom_range(0, 30)); check_run("random");
        end
        noise_en = 1'b0;

        rst_abort("reset in wait", 1'b0);
        rst_abort("reset in issue", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter: ADDR_W, 8, width of instruction address.
REQ-002 Parameter: LAST_ADDR, 255, highest legal instruction address.
REQ-003 Parameter: RSP_TIMEOUT, 1024, maximum cycles to wait for an I2C response.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins execution at address 0 when idle.
REQ-007 reg_addr  out  ADDR_W  instruction address to memory, registered.
REQ-008 read_data  in  32  instruction word {op[31:24], dev[23:16], reg[15:8], data[7:0]}, valid one cycle after reg_addr.
REQ-009 mem_error  in  4  memory error code; nonzero = invalid address.
REQ-010 i2c_req_valid / i2c_req_ready  out / in  1 / 1  I2C request handshake.
REQ-011 i2c_rw  out  1  1 = read, 0 = write.
REQ-012 i2c_dev, i2c_reg, i2c_wdata  out  8 each  from instruction fields dev, reg and data.
REQ-013 i2c_rsp_valid  in  1  one-cycle pulse; transaction complete.
REQ-014 i2c_rsp_nack  in  1  qualified by i2c_rsp_valid; device did not acknowledge.
REQ-015 i2c_rsp_data  in  8  read byte, qualified by i2c_rsp_valid.
REQ-016 rd_data / rd_valid  out  8 / 1  captured read byte; one-cycle strobe.
REQ-017 busy  out  1  high from start acceptance until DONE or ERR.
REQ-018 done  out  1  one-cycle pulse on normal completion.
REQ-019 err_code  out  4  0 none, 1 memory address error, 2 illegal opcode, 3 NACK, 4 timeout; holds until next start or reset.

Function
REQ-020 The block SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, ADVANCE, ERR.
REQ-021 IDLE: on start, set pc=0, reg_addr=0, clear err_code, assert busy, go to FETCH; start is ignored in all other states.
REQ-022 FETCH: hold reg_addr=pc for one cycle, then go to DECODE; memory read latency is fixed at 1 cycle.
REQ-023 DECODE: if mem_error!=0, set err_code=1 and go to ERR; decode takes priority over op.
REQ-024 DECODE op 0x00 (NOP): go to ADVANCE with no I2C activity.
REQ-025 DECODE op 0x01 or 0x02: latch the fields, set i2c_rw=(op==0x01), go to ISSUE.
REQ-026 DECODE op 0xFF (END): pulse done, drop busy, return to IDLE.
REQ-027 DECODE any other op: set err_code=2 and go to ERR.
REQ-028 ISSUE: hold i2c_req_valid high and i2c_* fields stable until i2c_req_ready=1 in the same cycle; then go to WAIT_RSP next cycle with valid low.
REQ-029 WAIT_RSP: count cycles from 0; on i2c_rsp_valid with nack=1, set err_code=3 and go to ERR.
REQ-030 WAIT_RSP, on i2c_rsp_valid with nack=0: for a read, set rd_data=i2c_rsp_data and pulse rd_valid for 1 cycle; then go to ADVANCE.
REQ-031 WAIT_RSP: if the count reaches RSP_TIMEOUT with no response, set err_code=4 and go to ERR; a response in the same cycle as timeout wins.
REQ-032 The block SHALL ignore i2c_rsp_valid in any state other than WAIT_RSP.
REQ-033 ADVANCE: if pc==LAST_ADDR, pulse done and go to IDLE (no wrap); else pc=pc+1 and go to FETCH.
REQ-034 ERR: drop busy, hold err_code, issue no requests; start re-enters as from IDLE.
REQ-035 rd_data SHALL hold its last value between strobes.
REQ-036 Minimum cost per instruction: NOP 3 cycles (FETCH, DECODE, ADVANCE); I2C instruction 4 cycles plus handshake and response wait.

Reset
REQ-037 While reset is high at a clock edge, the block SHALL enter IDLE.
REQ-038 Reset values: pc=0, reg_addr=0, i2c_req_valid=0, i2c_rw=0, i2c_dev/reg/wdata=0, rd_data=0, rd_valid=0, busy=0, done=0, err_code=0, timeout counter=0.
REQ-039 Reset mid-transaction, including with i2c_req_valid high, SHALL abort with no further request or done.

Verification
REQ-040 Memory {0:0x0200F0A5, 1:0xFF000000}, start -> one write request (dev 0x00, reg 0xF0, wdata 0xA5, rw=0), then done; err_code=0.
REQ-041 Memory {0:0x011D2B00, 1:0xFF…}, response data 0x5C -> rw=1, dev 0x1D, reg 0x2B; rd_data=0x5C with a 1-cycle rd_valid; done.
REQ-042 i2c_req_ready held low 5 cycles -> valid and fields stable for all 5 cycles; exactly one request accepted.
REQ-043 Response with nack=1 -> err_code=3; busy falls; no fetch of address 1; a new start restarts at address 0.
REQ-044 No response -> err_code=4 after exactly RSP_TIMEOUT cycles; op 0x03 -> err_code=2; mem_error=1 -> err_code=1.
REQ-045 All NOPs to LAST_ADDR -> done after address 255; reg_addr never wraps to 0; reset during WAIT_RSP -> all outputs at reset values the next cycle.
